// File: rtl/ps2_pkg.sv
// Shared PS/2 keyboard constants, decoder state type and frame-check helper.
// Imported by the tracker and any future keyboard consumer.
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK  = 8'hF0;
    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam int         FRAME_BITS = 11;

    typedef enum logic {
        DEC_MAKE  = 1'b0,
        DEC_BREAK = 1'b1
    } dec_state_e;

    // Odd parity: the data bits plus the parity bit hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return (^data) ^ par;
    endfunction

endpackage

// File: rtl/ps2_key_tracker_if.sv
// PS/2 pin inputs and display-driver outputs of the key tracker.
// The master modport is the tracker; the slave modport is the pin/display side.
interface ps2_key_tracker_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] key_count;
    logic [7:0] ascii_code;
    logic [7:0] scan_code;
    logic       key_pressed;
    logic       rx_err;

    modport master (
        input  ps2_clk, ps2_data,
        output key_count, ascii_code, scan_code, key_pressed, rx_err
    );

    modport slave (
        output ps2_clk, ps2_data,
        input  key_count, ascii_code, scan_code, key_pressed, rx_err
    );
endinterface

// File: rtl/scancode_to_ascii.sv
// Combinational ROM from PS/2 set-2 make codes to ASCII.
// Letters map to lowercase; unmapped codes give 8'h00.
module scancode_to_ascii (
    input  logic [7:0] scan_i,
    output logic [7:0] ascii_o
);

    // Case ROM covering letters, digits, space and enter.
    always_comb begin
        ascii_o = 8'h00;
        case (scan_i)
            8'h1C: ascii_o = 8'h61;  8'h32: ascii_o = 8'h62;  8'h21: ascii_o = 8'h63;
            8'h23: ascii_o = 8'h64;  8'h24: ascii_o = 8'h65;  8'h2B: ascii_o = 8'h66;
            8'h34: ascii_o = 8'h67;  8'h33: ascii_o = 8'h68;  8'h43: ascii_o = 8'h69;
            8'h3B: ascii_o = 8'h6A;  8'h42: ascii_o = 8'h6B;  8'h4B: ascii_o = 8'h6C;
            8'h3A: ascii_o = 8'h6D;  8'h31: ascii_o = 8'h6E;  8'h44: ascii_o = 8'h6F;
            8'h4D: ascii_o = 8'h70;  8'h15: ascii_o = 8'h71;  8'h2D: ascii_o = 8'h72;
            8'h1B: ascii_o = 8'h73;  8'h2C: ascii_o = 8'h74;  8'h3C: ascii_o = 8'h75;
            8'h2A: ascii_o = 8'h76;  8'h1D: ascii_o = 8'h77;  8'h22: ascii_o = 8'h78;
            8'h35: ascii_o = 8'h79;  8'h1A: ascii_o = 8'h7A;
            8'h45: ascii_o = 8'h30;  8'h16: ascii_o = 8'h31;  8'h1E: ascii_o = 8'h32;
            8'h26: ascii_o = 8'h33;  8'h25: ascii_o = 8'h34;  8'h2E: ascii_o = 8'h35;
            8'h36: ascii_o = 8'h36;  8'h3D: ascii_o = 8'h37;  8'h3E: ascii_o = 8'h38;
            8'h46: ascii_o = 8'h39;
            8'h29: ascii_o = 8'h20;  8'h5A: ascii_o = 8'h0D;
            default: ascii_o = 8'h00;
        endcase
    end

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 device-to-host receiver with make/break/typematic decoding that feeds
// the seven-segment display driver (key count, ASCII, scan code, held flag).
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    ps2_key_tracker_if.master     bus
);

    localparam int          TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  LAST_BIT = 4'(FRAME_BITS - 1);

    logic [SYNC_STAGES-1:0]  clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0]  dat_sync_q, dat_sync_d;
    logic                    clk_prev_q, clk_prev_d;
    logic [3:0]              bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-2:0]   shift_q, shift_d;
    logic [TW-1:0]           to_cnt_q, to_cnt_d;
    logic [7:0]              rx_byte_q, rx_byte_d;
    logic                    byte_stb_q, byte_stb_d;
    logic                    rx_err_q, rx_err_d;
    logic                    fall_s, dat_s, frame_ok_s;
    logic [7:0]              map_ascii_s;

    dec_state_e              dec_state_q;
    logic [7:0]              key_count_q, ascii_code_q, scan_code_q;
    logic                    key_pressed_q;

    scancode_to_ascii u_map (
        .scan_i  (rx_byte_q),
        .ascii_o (map_ascii_s)
    );

    // Synchroniser, edge detect, bit framing and mid-frame timeout.
    always_comb begin
        clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], bus.ps2_clk};
        dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], bus.ps2_data};
        clk_prev_d = clk_sync_q[SYNC_STAGES-1];
        dat_s      = dat_sync_q[SYNC_STAGES-1];
        fall_s     = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
        // shift_q[0] holds start, [8:1] data LSB first, [9] parity; dat_s is stop.
        frame_ok_s = ~shift_q[0] & dat_s & odd_parity_ok(shift_q[8:1], shift_q[9]);
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        to_cnt_d   = to_cnt_q;
        rx_byte_d  = rx_byte_q;
        byte_stb_d = 1'b0;
        rx_err_d   = 1'b0;
        if (fall_s) begin
            to_cnt_d = '0;
            if (bit_cnt_q == LAST_BIT) begin
                bit_cnt_d  = 4'd0;
                byte_stb_d = frame_ok_s;
                rx_err_d   = ~frame_ok_s;
                rx_byte_d  = shift_q[8:1];
            end else begin
                bit_cnt_d = bit_cnt_q + 4'd1;
                shift_d   = {dat_s, shift_q[FRAME_BITS-2:1]};
            end
        end else if (bit_cnt_q != 4'd0) begin
            if (to_cnt_q == TO_LAST) begin
                bit_cnt_d = 4'd0;
                to_cnt_d  = '0;
            end else begin
                to_cnt_d = to_cnt_q + TW'(1);
            end
        end else begin
            to_cnt_d = '0;
        end
    end

    // Receiver state; synchronisers reset to the idle-high line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q <= {SYNC_STAGES{1'b1}};
            dat_sync_q <= {SYNC_STAGES{1'b1}};
            clk_prev_q <= 1'b1;
            bit_cnt_q  <= 4'd0;
            shift_q    <= '0;
            to_cnt_q   <= '0;
            rx_byte_q  <= 8'h00;
            byte_stb_q <= 1'b0;
            rx_err_q   <= 1'b0;
        end else begin
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            clk_prev_q <= clk_prev_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            to_cnt_q   <= to_cnt_d;
            rx_byte_q  <= rx_byte_d;
            byte_stb_q <= byte_stb_d;
            rx_err_q   <= rx_err_d;
        end
    end

    // Make/break/typematic decoder with registered display outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_state_q   <= DEC_MAKE;
            key_count_q   <= 8'h00;
            ascii_code_q  <= 8'h00;
            scan_code_q   <= 8'h00;
            key_pressed_q <= 1'b0;
        end else if (byte_stb_q) begin
            case (dec_state_q)
                DEC_MAKE: begin
                    if (rx_byte_q == PS2_EXT) begin
                        dec_state_q <= DEC_MAKE;
                    end else if (rx_byte_q == PS2_BREAK) begin
                        dec_state_q <= DEC_BREAK;
                    end else if (!(key_pressed_q && rx_byte_q == scan_code_q)) begin
                        scan_code_q   <= rx_byte_q;
                        ascii_code_q  <= map_ascii_s;
                        key_pressed_q <= 1'b1;
                        key_count_q   <= key_count_q + 8'd1;
                    end
                end
                DEC_BREAK: begin
                    if (rx_byte_q != PS2_EXT) begin
                        dec_state_q <= DEC_MAKE;
                        if (rx_byte_q == scan_code_q) begin
                            key_pressed_q <= 1'b0;
                        end
                    end
                end
                default: dec_state_q <= DEC_MAKE;
            endcase
        end
    end

    assign bus.key_count   = key_count_q;
    assign bus.ascii_code  = ascii_code_q;
    assign bus.scan_code   = scan_code_q;
    assign bus.key_pressed = key_pressed_q;
    assign bus.rx_err      = rx_err_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed self-checking bench for ps2_key_tracker: framing, decoding,
// error/timeout handling, count wrap and mid-frame reset.
module tb_ps2_key_tracker;

    localparam int TO_CYC = 200;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;
    int   err_pulses;
    int   err_wide;
    logic rx_err_prev;

    ps2_key_tracker_if bus ();

    ps2_key_tracker #(
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count rx_err pulses and any pulse lasting more than one cycle.
    always @(negedge clk) begin
        if (rst) begin
            rx_err_prev <= 1'b0;
        end else begin
            if (bus.rx_err) err_pulses <= err_pulses + 1;
            if (bus.rx_err && rx_err_prev) err_wide <= err_wide + 1;
            rx_err_prev <= bus.rx_err;
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic chk_out(input string tag, input logic [7:0] cnt, input logic [7:0] asc,
                           input logic [7:0] scn, input logic prs);
        chk({tag, ".key_count"},   bus.key_count,  cnt);
        chk({tag, ".ascii_code"},  bus.ascii_code, asc);
        chk({tag, ".scan_code"},   bus.scan_code,  scn);
        chk({tag, ".key_pressed"}, {7'd0, bus.key_pressed}, {7'd0, prs});
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        bus.ps2_data = b;
        repeat (2) @(negedge clk);
        bus.ps2_clk = 1'b0;
        repeat (2) @(negedge clk);
        bus.ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop);
        logic par;
        par = ~(^d) ^ par_flip;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(stop);
        repeat (4) @(negedge clk);
    endtask

    task automatic send_key(input logic [7:0] d);
        send_frame(d, 1'b0, 1'b1);
    endtask

    initial begin
        n_chk = 0; n_pass = 0; err_pulses = 0; err_wide = 0;
        bus.ps2_clk = 1'b1; bus.ps2_data = 1'b1;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk_out("reset", 8'h00, 8'h00, 8'h00, 1'b0);
        chk("reset.rx_err", {7'd0, bus.rx_err}, 8'h00);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // 1: single press
        send_key(8'h1C);
        chk_out("press_1c", 8'h01, 8'h61, 8'h1C, 1'b1);
        chk_int("press_1c.err", err_pulses, 0);

        // 2: typematic then release
        send_key(8'h1C); send_key(8'h1C); send_key(8'h1C);
        chk_out("typematic", 8'h01, 8'h61, 8'h1C, 1'b1);
        send_key(8'hF0);
        chk_out("break_prefix", 8'h01, 8'h61, 8'h1C, 1'b1);
        send_key(8'h1C);
        chk_out("release_1c", 8'h01, 8'h61, 8'h1C, 1'b0);

        // 3: bad parity, bad stop
        send_frame(8'h1C, 1'b1, 1'b1);
        chk_int("bad_parity.err", err_pulses, 1);
        chk_out("bad_parity", 8'h01, 8'h61, 8'h1C, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        chk_int("bad_stop.err", err_pulses, 2);
        chk_int("err_single_cycle", err_wide, 0);
        chk_out("bad_stop", 8'h01, 8'h61, 8'h1C, 1'b0);

        // 4: truncated frame then timeout recovery
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        repeat (TO_CYC + 10) @(negedge clk);
        send_key(8'h32);
        chk_out("after_timeout", 8'h02, 8'h62, 8'h32, 1'b1);
        chk_int("after_timeout.err", err_pulses, 2);

        // 5: overlapping keys, extended prefix, unmapped code
        send_key(8'hF0); send_key(8'h32);
        chk_out("release_32", 8'h02, 8'h62, 8'h32, 1'b0);
        send_key(8'h1C); send_key(8'h32);
        chk_out("two_keys", 8'h04, 8'h62, 8'h32, 1'b1);
        send_key(8'hF0); send_key(8'h1C);
        chk_out("old_key_released", 8'h04, 8'h62, 8'h32, 1'b1);
        send_key(8'hF0); send_key(8'h32);
        chk_out("newest_released", 8'h04, 8'h62, 8'h32, 1'b0);
        send_key(8'hE0);
        chk_out("ext_prefix", 8'h04, 8'h62, 8'h32, 1'b0);
        send_key(8'h29);
        chk_out("ext_space", 8'h05, 8'h20, 8'h29, 1'b1);
        send_key(8'hF0); send_key(8'hE0); send_key(8'h29);
        chk_out("ext_release", 8'h05, 8'h20, 8'h29, 1'b0);
        send_key(8'h05);
        chk_out("unmapped", 8'h06, 8'h00, 8'h05, 1'b1);

        // 6: mid-frame reset, count wrap, reset again and recover
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_out("midframe_rst", 8'h00, 8'h00, 8'h00, 1'b0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 255; i++) begin
            send_key(8'h45); send_key(8'hF0); send_key(8'h45);
        end
        chk_out("count_ff", 8'hFF, 8'h30, 8'h45, 1'b0);
        send_key(8'h45); send_key(8'hF0); send_key(8'h45);
        chk_out("count_wrap", 8'h00, 8'h30, 8'h45, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_out("midframe_rst2", 8'h00, 8'h00, 8'h00, 1'b0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        send_key(8'h16);
        chk_out("after_rst", 8'h01, 8'h31, 8'h16, 1'b1);
        chk_int("final.err_wide", err_wide, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
